heap_sift_down_seq: RTL and testbench
=====================================

// Module: heap_sift_down_seq
// PURPOSE
//  - Sequential min-heap sift-down engine for the HeapSort datapath; consumer of the per-node swap-index decision.
//  - Loads a 5-entry heap of signed 32-bit keys, a start index and a heap size.
//  - Each cycle it picks the swap target and exchanges parent and child, until the node settles.
//  - Returns the repaired heap with a done pulse. It sits between the sort controller (extract/replace root) and the heap register.
// PARAMETERS
//  - N_ELEM   5   heap capacity (entries); fixed at 5 for this build.
//  - KEY_W    32  key width, signed two's complement.
//  - IDX_W    16  index/size width, unsigned.
// PORTS
//  - system1000       in   1    clock, rising edge.
//  - system1000_rstn  in   1    asynchronous active-low reset.
//  - start            in   1    request; sampled only in IDLE.
//  - heap_in          in   160  heap vector; entry 0 at [159:128], entry 4 at [31:0].
//  - idx_in           in   16   node to sift down.
//  - size_in          in   16   live heap size; values > 5 clamp to 5.
//  - busy             out  1    high from the cycle after start is accepted until done.
//  - done             out  1    one-cycle pulse; heap_out valid from this cycle.
//  - heap_out         out  160  sifted heap, same packing as heap_in; held until next accept.
//  - swap_cnt         out  3    swaps performed (present only with HEAP_SIFT_SWAP_CNT_EN).
// BEHAVIOUR
//  - Reset (async, rstn=0): state=IDLE, busy=0, done=0, heap_out=0, swap_cnt=0, internal regs=0.
//  - FSM IDLE -> SIFT -> DONE -> IDLE. All outputs registered.
//  - IDLE: on start=1, capture heap_in/idx_in/clamped size; go to SIFT. busy=1 next cycle.
//  - SIFT, per cycle, with cur=current index:
//    - c1=2*cur+1, c2=2*cur+2, computed in 17 bits (no wrap).
//    - best=cur.
//    - If c1<size and key[best]>key[c1] (signed), then best=c1.
//    - Then if c2<size and key[best]>key[c2], then best=c2.
//    - Ties keep the parent or left child.
//  - If best!=cur: swap key[cur] and key[best], cur<=best, stay in SIFT.
//  - If best==cur: go to DONE.
//  - DONE: done=1 and busy=0 for exactly one cycle; heap_out holds the result; return to IDLE.
//  - Latency: with k swaps, done is high in the cycle after edge k+1 counted from the accepting edge (minimum 1, maximum 3 for N=5).
//  - start while busy or in DONE: ignored, not queued.
//  - idx_in>=size or size_in=0: no swap; DONE after a single SIFT cycle; heap_out = heap_in.
//  - Entries at indices >= size are never read for comparison and never modified.
//  - Reset mid-operation: aborts immediately to reset values; no done pulse.
// CONFIGURATION
//  - HEAP_SIFT_SWAP_CNT_EN defined: swap_cnt port present.
//    - Cleared on accept, +1 per swap (saturating at 7), valid with done, held afterwards.
//  - Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared package heap_sort_pkg:
//    - N_ELEM, KEY_W, IDX_W.
//    - key_t (signed [31:0]), idx_t ([15:0]).
//    - FSM state enum {IDLE, SIFT, DONE}.
//    - pack/unpack functions for the 160-bit vector.
//  - One sub-module, heap_swap_sel: combinational chooser (keys, cur, size -> best).
//    - Contains the child-index arithmetic and the two signed compares.
//    - The engine keeps only the FSM, key registers and swap mux.
// TESTING
//  - Root sift, 2 levels:
//    - Stimulus: heap=[9,2,3,4,5], idx=0, size=5.
//    - Response: heap_out=[2,4,3,9,5], 2 swaps, done on 3rd cycle after accept.
//  - Already valid:
//    - Stimulus: [1,2,3,4,5], idx=0, size=5.
//    - Response: no change, done 1 cycle after accept, swap_cnt=0.
//  - Size bound:
//    - Stimulus: [9,2,3,-7,-8], idx=0, size=3.
//    - Response: [2,9,3,-7,-8]; entries 3,4 untouched.
//  - Signed and ties:
//    - Stimulus: [5,-1,-1,0,0], idx=0, size=5.
//    - Response: left chosen, [-1,0,-1,5,0], 2 swaps.
//  - Out of range and size clamp:
//    - Stimulus: idx=4, size=5.
//    - Response: unchanged, done 1 cycle after accept.
//    - Stimulus: size_in=200.
//    - Response: behaves as size=5.
//  - Protocol:
//    - start held high while busy: ignored.
//    - rstn pulsed low mid-SIFT: outputs 0 asynchronously, no done pulse.
//    - A new start after reset completes normally.

Source files
------------

// File: rtl/heap_sort_pkg.sv
// Shared types, sizes and heap-vector pack/unpack helpers for the HeapSort datapath.
package heap_sort_pkg;

    localparam int unsigned N_ELEM = 5;
    localparam int unsigned KEY_W  = 32;
    localparam int unsigned IDX_W  = 16;
    localparam int unsigned HEAP_W = N_ELEM * KEY_W;
    localparam int unsigned CNT_W  = 3;

    typedef logic signed [KEY_W-1:0] key_t;
    typedef logic [IDX_W-1:0]        idx_t;
    typedef logic [HEAP_W-1:0]       heap_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIFT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entry 0 sits in the most significant key slot; out-of-range reads return 0.
    function automatic key_t heap_unpack_key(input heap_vec_t vec, input int unsigned i);
        key_t k;
        k = '0;
        for (int unsigned j = 0; j < N_ELEM; j++) begin
            if (j == i) begin
                k = key_t'(vec[HEAP_W-1-KEY_W*j -: KEY_W]);
            end
        end
        return k;
    endfunction

    function automatic heap_vec_t heap_pack_key(input heap_vec_t vec, input int unsigned i,
                                                input key_t key);
        heap_vec_t v;
        v = vec;
        for (int unsigned j = 0; j < N_ELEM; j++) begin
            if (j == i) begin
                v[HEAP_W-1-KEY_W*j -: KEY_W] = key;
            end
        end
        return v;
    endfunction

    function automatic idx_t clamp_size(input idx_t s);
        return (s > IDX_W'(N_ELEM)) ? IDX_W'(N_ELEM) : s;
    endfunction

endpackage

// File: rtl/heap_swap_sel.sv
// Combinational swap-target chooser: smallest of parent and live children, ties keep the lower index.
module heap_swap_sel
    import heap_sort_pkg::*;
(
    input  logic [HEAP_W-1:0] keys_i,
    input  logic [IDX_W-1:0]  cur_i,
    input  logic [IDX_W-1:0]  size_i,
    output logic [IDX_W-1:0]  best_c
);

    logic [IDX_W:0] c1;
    logic [IDX_W:0] c2;
    logic [IDX_W:0] size_x;
    key_t           k_cur;
    key_t           k1;
    key_t           k2;
    key_t           best_key;

    // Child indices carry one extra bit so a large cur never wraps into the live range.
    always_comb begin
        c1       = {cur_i, 1'b0} + (IDX_W+1)'(1);
        c2       = {cur_i, 1'b0} + (IDX_W+1)'(2);
        size_x   = {1'b0, size_i};
        k_cur    = heap_unpack_key(keys_i, 32'(cur_i));
        k1       = heap_unpack_key(keys_i, 32'(c1));
        k2       = heap_unpack_key(keys_i, 32'(c2));
        best_c   = cur_i;
        best_key = k_cur;
        if ((c1 < size_x) && (best_key > k1)) begin
            best_c   = c1[IDX_W-1:0];
            best_key = k1;
        end
        if ((c2 < size_x) && (best_key > k2)) begin
            best_c = c2[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/heap_sift_down_seq.sv
// Sequential min-heap sift-down engine: one compare-and-swap per cycle until the node settles.
// Optional swap counter output enabled by defining HEAP_SIFT_SWAP_CNT_EN.
module heap_sift_down_seq
    import heap_sort_pkg::*;
(
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              start,
    input  logic [HEAP_W-1:0] heap_in,
    input  logic [IDX_W-1:0]  idx_in,
    input  logic [IDX_W-1:0]  size_in,
    output logic              busy,
    output logic              done,
    output logic [HEAP_W-1:0] heap_out
`ifdef HEAP_SIFT_SWAP_CNT_EN
    ,
    output logic [CNT_W-1:0]  swap_cnt
`endif
);

    state_t            state_q, state_d;
    logic [HEAP_W-1:0] keys_q, keys_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]  size_q, size_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HEAP_W-1:0] heap_out_q, heap_out_d;
    logic [IDX_W-1:0]  best;
    key_t              key_cur;
    key_t              key_best;
`ifdef HEAP_SIFT_SWAP_CNT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    heap_swap_sel u_sel (
        .keys_i (keys_q),
        .cur_i  (cur_q),
        .size_i (size_q),
        .best_c (best)
    );

    always_comb begin
        state_d    = state_q;
        keys_d     = keys_q;
        cur_d      = cur_q;
        size_d     = size_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        heap_out_d = heap_out_q;
`ifdef HEAP_SIFT_SWAP_CNT_EN
        cnt_d      = cnt_q;
`endif
        key_cur    = heap_unpack_key(keys_q, 32'(cur_q));
        key_best   = heap_unpack_key(keys_q, 32'(best));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    keys_d  = heap_in;
                    cur_d   = idx_in;
                    size_d  = clamp_size(size_in);
                    busy_d  = 1'b1;
                    state_d = SIFT;
`ifdef HEAP_SIFT_SWAP_CNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            SIFT: begin
                if (best != cur_q) begin
                    keys_d = heap_pack_key(heap_pack_key(keys_q, 32'(cur_q), key_best),
                                           32'(best), key_cur);
                    cur_d  = best;
`ifdef HEAP_SIFT_SWAP_CNT_EN
                    cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`endif
                end else begin
                    heap_out_d = keys_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q    <= IDLE;
            keys_q     <= '0;
            cur_q      <= '0;
            size_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            heap_out_q <= '0;
`ifdef HEAP_SIFT_SWAP_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            keys_q     <= keys_d;
            cur_q      <= cur_d;
            size_q     <= size_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            heap_out_q <= heap_out_d;
`ifdef HEAP_SIFT_SWAP_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign heap_out = heap_out_q;
`ifdef HEAP_SIFT_SWAP_CNT_EN
    assign swap_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_heap_sift_down_seq.sv
// Directed bench for heap_sift_down_seq: array-level sift model, per-cycle output comparison.
module tb_heap_sift_down_seq;

    typedef int arr_t [5];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [159:0] heap_in;
    logic [15:0]  idx_in;
    logic [15:0]  size_in;
    logic         busy;
    logic         done;
    logic [159:0] heap_out;
`ifdef HEAP_SIFT_SWAP_CNT_EN
    logic [2:0]   swap_cnt;
`endif

    int           checks = 0;
    int           errors = 0;
    logic         exp_busy;
    logic         exp_done;
    logic [159:0] exp_heap;
    int           exp_cnt;

    always #5 clk = ~clk;

    heap_sift_down_seq dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .start           (start),
        .heap_in         (heap_in),
        .idx_in          (idx_in),
        .size_in         (size_in),
        .busy            (busy),
        .done            (done),
        .heap_out        (heap_out)
`ifdef HEAP_SIFT_SWAP_CNT_EN
        ,
        .swap_cnt        (swap_cnt)
`endif
    );

    function automatic logic [159:0] pack(input arr_t h);
        logic [159:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v[159-32*i -: 32] = 32'(h[i]);
        return v;
    endfunction

    // Array-level sift-down: move the node toward the smallest live child until it is no larger.
    function automatic void model(input arr_t h, input int idx, input int size,
                                  output arr_t r, output int k);
        int sz;
        int cur;
        int best;
        int t;
        sz  = (size > 5) ? 5 : size;
        r   = h;
        k   = 0;
        cur = idx;
        while (cur < sz) begin
            best = cur;
            for (int c = 2*cur+1; c <= 2*cur+2; c++) begin
                if (c < sz && r[c] < r[best]) best = c;
            end
            if (best == cur) break;
            t       = r[cur];
            r[cur]  = r[best];
            r[best] = t;
            cur     = best;
            k++;
        end
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag);
        check({tag, " busy"}, 160'(busy), 160'(exp_busy));
        check({tag, " done"}, 160'(done), 160'(exp_done));
        check({tag, " heap_out"}, heap_out, exp_heap);
`ifdef HEAP_SIFT_SWAP_CNT_EN
        if (!exp_busy) check({tag, " swap_cnt"}, 160'(swap_cnt), 160'(exp_cnt));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: pins the model against a literal, then checks every cycle to idle.
    task automatic run_op(input string name, input arr_t h, input int idx, input int size,
                          input arr_t lit, input int lit_k, input bit hold);
        arr_t m;
        int   k;
        model(h, idx, size, m, k);
        check({name, " model_heap"}, pack(m), pack(lit));
        check({name, " model_swaps"}, 160'(k), 160'(lit_k));
        heap_in = pack(h);
        idx_in  = 16'(idx);
        size_in = 16'(size);
        start   = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        compare({name, " accept"});
        for (int e = 1; e <= k + 2; e++) begin
            tick();
            if (e == k + 1) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
                exp_heap = pack(m);
                exp_cnt  = (k > 7) ? 7 : k;
                start    = 1'b0;
            end else if (e == k + 2) begin
                exp_done = 1'b0;
            end
            compare($sformatf("%s e%0d", name, e));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        heap_in  = '0;
        idx_in   = '0;
        size_in  = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_heap = '0;
        exp_cnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset");
        rst_n = 1'b1;
        tick();
        compare("idle");

        run_op("root2",  '{9, 2, 3, 4, 5},   0, 5,   '{2, 4, 3, 9, 5},   2, 1'b0);
        run_op("valid",  '{1, 2, 3, 4, 5},   0, 5,   '{1, 2, 3, 4, 5},   0, 1'b0);
        run_op("size3",  '{9, 2, 3, -7, -8}, 0, 3,   '{2, 9, 3, -7, -8}, 1, 1'b0);
        run_op("ties",   '{5, -1, -1, 0, 0}, 0, 5,   '{-1, 0, -1, 5, 0}, 2, 1'b0);
        run_op("idx4",   '{7, 1, 2, 3, 0},   4, 5,   '{7, 1, 2, 3, 0},   0, 1'b0);
        run_op("clamp",  '{9, 2, 3, 4, 5},   0, 200, '{2, 4, 3, 9, 5},   2, 1'b0);
        run_op("size0",  '{3, 1, 2, 0, 0},   0, 0,   '{3, 1, 2, 0, 0},   0, 1'b0);
        run_op("idx1",   '{0, 9, 1, 2, 3},   1, 5,   '{0, 2, 1, 9, 3},   1, 1'b0);
        run_op("extreme", '{32'h7fffffff, int'(32'h80000000), 0, 1, 2}, 0, 5,
               '{int'(32'h80000000), 1, 0, 32'h7fffffff, 2}, 2, 1'b0);
        run_op("hold",   '{9, 2, 3, 4, 5},   0, 5,   '{2, 4, 3, 9, 5},   2, 1'b1);

        // Reset in the middle of a sift: outputs clear at once, no done pulse follows.
        heap_in = pack('{9, 2, 3, 4, 5});
        idx_in  = 16'd0;
        size_in = 16'd5;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        compare("mid accept");
        tick();
        compare("mid sift");
        rst_n = 1'b0;
        #1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_heap = '0;
        exp_cnt  = 0;
        compare("mid reset async");
        repeat (3) begin
            tick();
            compare("in reset");
        end
        rst_n = 1'b1;
        tick();
        compare("post reset idle");

        run_op("after_rst", '{8, 6, 7, 1, 0}, 0, 5, '{6, 0, 7, 1, 8}, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
